// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter for a shared
// single-port RAM with registered read data. One access per cycle, no queuing.
// Conflict policy: fixed data-port priority by default; define
// MEM_ARBITER_RR_EN for round-robin between the two requesters.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       conflict_cnt
);

  localparam logic [0:0] OWNER_IF = 1'b0;
  localparam logic [0:0] OWNER_D  = 1'b1;

  logic [0:0]        lastOwner;
  logic [ADDR_W-1:0] addrHold;
  logic              readPending;
  logic [15:0]       conflictCnt;
  logic              conflict;
  logic              dWins;

  // Conflict resolution: decides whether the data port wins a simultaneous request
  always_comb begin
    conflict = if_req & d_req;
`ifdef MEM_ARBITER_RR_EN
    dWins = (lastOwner == OWNER_IF);
`else
    dWins = 1'b1;
`endif
  end

  // Grants and shared-RAM drive; grants are suppressed while in reset
  always_comb begin
    d_gnt  = clear & d_req & (~if_req | dWins);
    if_gnt = clear & if_req & (~d_req | ~dWins);
    if (d_gnt) begin
      mem_addr = d_addr;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end else begin
      mem_addr = addrHold;
    end
    mem_wren = d_gnt & d_we;
    mem_din  = d_wdata;
  end

  // Read-return qualification. lastOwner always names the previous cycle's
  // grantee, so a single pending flag plus lastOwner steers rvalid.
  always_comb begin
    if_rvalid = readPending & (lastOwner == OWNER_IF);
    d_rvalid  = readPending & (lastOwner == OWNER_D);
    if_rdata  = mem_dout;
    d_rdata   = mem_dout;
    conflict_cnt = conflictCnt;
  end

  // Arbitration state: owner, held address and outstanding-read flag
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      lastOwner   <= OWNER_IF;
      addrHold    <= '0;
      readPending <= 1'b0;
    end else begin
      readPending <= if_gnt | (d_gnt & ~d_we);
      if (d_gnt) begin
        lastOwner <= OWNER_D;
        addrHold  <= d_addr;
      end else if (if_gnt) begin
        lastOwner <= OWNER_IF;
        addrHold  <= if_addr;
      end
    end
  end

  // Saturating count of cycles in which both requesters asked
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      conflictCnt <= '0;
    end else if (conflict && (conflictCnt != '1)) begin
      conflictCnt <= conflictCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with a registered-read RAM
// model. Expected grant pattern under conflict follows MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_wren;
  logic [31:0] mem_dout;
  logic [15:0] conflict_cnt;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clock(clock), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren),
    .mem_dout(mem_dout), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  // RAM model: contents start as 0xA000_0000 | address, registered read
  logic [31:0] ram [256];
  logic        ramReady = 1'b0;
  always @(posedge clock) begin
    if (!ramReady) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 | i;
      ramReady <= 1'b1;
      mem_dout <= '0;
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic expD;
    logic prevD;
    clear = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    // reset state, including requests presented during reset
    if_req = 1'b1; if_addr = 8'h33; d_req = 1'b1; d_we = 1'b1; d_addr = 8'h44;
    #1;
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;

    // lone fetch read
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 8'h05;
    #1;
    chk("if_gnt_lone", {31'd0, if_gnt}, 32'd1);
    chk("d_gnt_lone_if", {31'd0, d_gnt}, 32'd0);
    chk("mem_addr_if", {24'd0, mem_addr}, 32'h05);
    chk("wren_if_read", {31'd0, mem_wren}, 32'd0);
    @(posedge clock); #1;
    if_req = 1'b0; if_addr = 8'h77;
    #1;
    chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("if_rdata", if_rdata, 32'hA000_0005);
    chk("d_rvalid_on_if", {31'd0, d_rvalid}, 32'd0);
    chk("mem_addr_hold", {24'd0, mem_addr}, 32'h05);
    @(posedge clock); #1;
    chk("if_rvalid_once", {31'd0, if_rvalid}, 32'd0);

    // lone data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'hFF; d_wdata = 32'h41;
    #1;
    chk("d_gnt_wr", {31'd0, d_gnt}, 32'd1);
    chk("wren_wr", {31'd0, mem_wren}, 32'd1);
    chk("din_wr", mem_din, 32'h41);
    chk("mem_addr_wr", {24'd0, mem_addr}, 32'hFF);
    @(posedge clock); #1;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("d_rvalid_wr", {31'd0, d_rvalid}, 32'd0);
    chk("if_rvalid_wr", {31'd0, if_rvalid}, 32'd0);
    chk("wren_idle", {31'd0, mem_wren}, 32'd0);

    // data read-back of the written word
    @(posedge clock); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'hFF;
    #1;
    chk("d_gnt_rd", {31'd0, d_gnt}, 32'd1);
    @(posedge clock); #1;
    d_req = 1'b0;
    #1;
    chk("d_rvalid_rd", {31'd0, d_rvalid}, 32'd1);
    chk("d_rdata_rd", d_rdata, 32'h41);

    // reset the cycle after a data read grant discards the read
    @(posedge clock); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    #1;
    chk("d_gnt_pre_rst", {31'd0, d_gnt}, 32'd1);
    @(posedge clock); #1;
    clear = 1'b0; d_req = 1'b0;
    #1;
    chk("abort_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("abort_d_gnt", {31'd0, d_gnt}, 32'd0);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("post_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);

    // four conflict cycles starting from reset
    if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    prevD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef MEM_ARBITER_RR_EN
      expD = (k % 2 == 0);
`else
      expD = 1'b1;
`endif
      chk($sformatf("conf%0d_d_gnt", k), {31'd0, d_gnt}, {31'd0, expD});
      chk($sformatf("conf%0d_if_gnt", k), {31'd0, if_gnt}, {31'd0, ~expD});
      chk($sformatf("conf%0d_addr", k), {24'd0, mem_addr}, expD ? 32'h20 : 32'h10);
      if (k > 0) begin
        chk($sformatf("conf%0d_d_rvalid", k), {31'd0, d_rvalid}, {31'd0, prevD});
        chk($sformatf("conf%0d_if_rvalid", k), {31'd0, if_rvalid}, {31'd0, ~prevD});
        chk($sformatf("conf%0d_rdata", k), prevD ? d_rdata : if_rdata,
            prevD ? 32'hA000_0020 : 32'hA000_0010);
      end
      prevD = expD;
      @(posedge clock); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    #1;
    chk("conf_last_d_rvalid", {31'd0, d_rvalid}, {31'd0, prevD});
    chk("conf_last_if_rvalid", {31'd0, if_rvalid}, {31'd0, ~prevD});
    chk("conflict_cnt_4", {16'd0, conflict_cnt}, 32'd4);

    // saturation of the conflict counter
    if_req = 1'b1; d_req = 1'b1;
    repeat (65530) @(posedge clock);
    #1;
    chk("conflict_cnt_fffe", {16'd0, conflict_cnt}, 32'hFFFE);
    @(posedge clock); #1;
    chk("conflict_cnt_ffff", {16'd0, conflict_cnt}, 32'hFFFF);
    repeat (5) @(posedge clock);
    #1;
    chk("conflict_cnt_sat", {16'd0, conflict_cnt}, 32'hFFFF);
    if_req = 1'b0; d_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
